// File: rtl/conv_3x3_channel_accum.sv
// conv_3x3_channel_accum
//   Sums CHANNEL_NUM_IN consecutive partial-sum frames (IMAGE_SIZE pixels each)
//   pixel-by-pixel into an on-chip buffer. On the last input channel the
//   saturated sum is registered out (optionally ReLU-clamped), giving one
//   finished output-channel frame. Repeats CHANNEL_NUM_OUT times per layer.
// Ports
//   clk        : rising-edge clock
//   reset      : asynchronous active-low reset
//   valid_in   : pxl_in carries a partial-sum pixel (always accepted)
//   pxl_in     : signed partial-sum pixel
//   pxl_out    : finished output pixel (registered, 1-cycle latency)
//   valid_out  : pxl_out valid this cycle
//   ch_out_idx : output channel currently being accumulated/emitted
//   layer_done : pulse with the last pixel of the last output channel
module conv_3x3_channel_accum #(
  parameter int DATA_WIDTH      = 32,
  parameter int IMAGE_WIDTH     = 32,
  parameter int IMAGE_HEIGHT    = 32,
  parameter int CHANNEL_NUM_IN  = 128,
  parameter int CHANNEL_NUM_OUT = 128,
  parameter int RELU            = 1,
  localparam int COUT_W = (CHANNEL_NUM_OUT > 1) ? $clog2(CHANNEL_NUM_OUT) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] pxl_in,
  output logic [DATA_WIDTH-1:0] pxl_out,
  output logic                  valid_out,
  output logic [COUT_W-1:0]     ch_out_idx,
  output logic                  layer_done
);

  localparam int IMAGE_SIZE = IMAGE_WIDTH * IMAGE_HEIGHT;
  localparam int PIX_W = (IMAGE_SIZE > 1) ? $clog2(IMAGE_SIZE) : 1;
  localparam int CIN_W = (CHANNEL_NUM_IN > 1) ? $clog2(CHANNEL_NUM_IN) : 1;

  localparam logic [PIX_W-1:0]  PIX_LAST  = PIX_W'(IMAGE_SIZE - 1);
  localparam logic [CIN_W-1:0]  CIN_LAST  = CIN_W'(CHANNEL_NUM_IN - 1);
  localparam logic [COUT_W-1:0] COUT_LAST = COUT_W'(CHANNEL_NUM_OUT - 1);

  localparam logic [DATA_WIDTH-1:0] SAT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] SAT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  logic [PIX_W-1:0]  pix_q, pix_d;
  logic [CIN_W-1:0]  ch_in_q, ch_in_d;
  logic [COUT_W-1:0] ch_out_q, ch_out_d;

  logic [DATA_WIDTH-1:0] pxl_out_q;
  logic                  valid_out_q, layer_done_q;

  // Accumulation buffer: async read, sync write, never reset
  logic [DATA_WIDTH-1:0] acc_mem [IMAGE_SIZE];

  logic                  first_ch, last_ch, last_pix, last_cout;
  logic [DATA_WIDTH-1:0] rd_val, sat_val, sum, relu_val;
  logic [DATA_WIDTH:0]   wide;

  assign first_ch  = (ch_in_q == '0);
  assign last_ch   = (ch_in_q == CIN_LAST);
  assign last_pix  = (pix_q == PIX_LAST);
  assign last_cout = (ch_out_q == COUT_LAST);

  assign rd_val = acc_mem[pix_q];

  // One extra bit of headroom: the top two bits disagree only on overflow,
  // and the top bit then gives the direction.
  assign wide = {rd_val[DATA_WIDTH-1], rd_val} + {pxl_in[DATA_WIDTH-1], pxl_in};

  always_comb begin
    sat_val = wide[DATA_WIDTH-1:0];
    case (wide[DATA_WIDTH:DATA_WIDTH-1])
      2'b01:   sat_val = SAT_MAX;
      2'b10:   sat_val = SAT_MIN;
      default: sat_val = wide[DATA_WIDTH-1:0];
    endcase
  end

  // First input channel overwrites the stale buffer word, so no clearing pass
  assign sum = first_ch ? pxl_in : sat_val;

  always_comb begin
    relu_val = sum;
    if (RELU != 0 && sum[DATA_WIDTH-1]) relu_val = '0;
  end

  // Nested wrap: pixel -> input channel -> output channel -> next layer
  always_comb begin
    pix_d    = pix_q;
    ch_in_d  = ch_in_q;
    ch_out_d = ch_out_q;
    if (valid_in) begin
      if (last_pix) begin
        pix_d = '0;
        if (last_ch) begin
          ch_in_d  = '0;
          ch_out_d = last_cout ? '0 : ch_out_q + COUT_W'(1);
        end else begin
          ch_in_d = ch_in_q + CIN_W'(1);
        end
      end else begin
        pix_d = pix_q + PIX_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (valid_in) acc_mem[pix_q] <= sum;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pix_q        <= '0;
      ch_in_q      <= '0;
      ch_out_q     <= '0;
      pxl_out_q    <= '0;
      valid_out_q  <= 1'b0;
      layer_done_q <= 1'b0;
    end else begin
      pix_q        <= pix_d;
      ch_in_q      <= ch_in_d;
      ch_out_q     <= ch_out_d;
      valid_out_q  <= valid_in && last_ch;
      layer_done_q <= valid_in && last_ch && last_pix && last_cout;
      if (valid_in && last_ch) pxl_out_q <= relu_val;
    end
  end

  assign pxl_out    = pxl_out_q;
  assign valid_out  = valid_out_q;
  assign layer_done = layer_done_q;
  assign ch_out_idx = ch_out_q;

endmodule

// File: tb/tb_conv_3x3_channel_accum.sv
module tb_conv_3x3_channel_accum;

  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          valid_in;
  logic [DW-1:0] pxl_in;

  logic [DW-1:0] pxl_r, pxl_l;
  logic          vo_r, vo_l, ld_r, ld_l;
  logic          idx_r, idx_l;

  always #5 clk = ~clk;

  conv_3x3_channel_accum #(
    .DATA_WIDTH(DW), .IMAGE_WIDTH(2), .IMAGE_HEIGHT(2),
    .CHANNEL_NUM_IN(3), .CHANNEL_NUM_OUT(2), .RELU(1)
  ) u_relu (
    .clk(clk), .reset(reset), .valid_in(valid_in), .pxl_in(pxl_in),
    .pxl_out(pxl_r), .valid_out(vo_r), .ch_out_idx(idx_r), .layer_done(ld_r)
  );

  conv_3x3_channel_accum #(
    .DATA_WIDTH(DW), .IMAGE_WIDTH(2), .IMAGE_HEIGHT(2),
    .CHANNEL_NUM_IN(3), .CHANNEL_NUM_OUT(2), .RELU(0)
  ) u_lin (
    .clk(clk), .reset(reset), .valid_in(valid_in), .pxl_in(pxl_in),
    .pxl_out(pxl_l), .valid_out(vo_l), .ch_out_idx(idx_l), .layer_done(ld_l)
  );

  typedef struct packed {
    logic [DW-1:0] r;
    logic [DW-1:0] l;
    logic          ld;
  } exp_t;

  exp_t q[$];

  int n_assert = 0;
  int n_fail   = 0;

  // reference model state
  int m_pix = 0, m_cin = 0, m_cout = 0;
  int acc [4];

  // monitor statistics
  int vcnt = 0, ld_cnt = 0, ld_pos1 = 0, ld_pos2 = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus; model advances on accepted beats only
  task automatic beat(input logic v, input logic [DW-1:0] x);
    int xs, s;
    exp_t e;
    valid_in = v;
    pxl_in   = x;
    @(posedge clk);
    #1;
    if (v) begin
      xs = int'($signed(x));
      s  = (m_cin == 0) ? xs : acc[m_pix] + xs;
      if (s > 32767)  s = 32767;
      if (s < -32768) s = -32768;
      acc[m_pix] = s;
      if (m_cin == 2) begin
        e.r  = (s < 0) ? 16'd0 : 16'(s);
        e.l  = 16'(s);
        e.ld = (m_pix == 3) && (m_cout == 1);
        q.push_back(e);
      end
      if (m_pix == 3) begin
        m_pix = 0;
        if (m_cin == 2) begin
          m_cin  = 0;
          m_cout = (m_cout == 1) ? 0 : m_cout + 1;
        end else begin
          m_cin = m_cin + 1;
        end
      end else begin
        m_pix = m_pix + 1;
      end
      chk("ch_out_idx_relu", {31'd0, idx_r}, m_cout);
      chk("ch_out_idx_lin",  {31'd0, idx_l}, m_cout);
    end
    valid_in = 1'b0;
  endtask

  task automatic frames(input int ch, input logic [DW-1:0] x);
    for (int i = 0; i < ch * 4; i++) beat(1'b1, x);
  endtask

  // Scoreboard consumer: outputs sampled mid-cycle
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      chk("valid_out_match", {31'd0, vo_l}, {31'd0, vo_r});
      if (vo_r) begin
        vcnt++;
        if (ld_r) begin
          ld_cnt++;
          if (ld_cnt == 1) ld_pos1 = vcnt;
          if (ld_cnt == 2) ld_pos2 = vcnt;
        end
        chk("output_expected", {31'd0, q.size() != 0}, 32'd1);
        if (q.size() != 0) begin
          e = q.pop_front();
          chk("pxl_out_relu",    {16'd0, pxl_r}, {16'd0, e.r});
          chk("pxl_out_lin",     {16'd0, pxl_l}, {16'd0, e.l});
          chk("layer_done_relu", {31'd0, ld_r},  {31'd0, e.ld});
          chk("layer_done_lin",  {31'd0, ld_l},  {31'd0, e.ld});
        end
      end else begin
        chk("layer_done_idle", {31'd0, ld_r}, 32'd0);
      end
    end
  end

  task automatic reset_checks(input string tag);
    chk({tag, "_pxl_out_relu"}, {16'd0, pxl_r}, 32'd0);
    chk({tag, "_pxl_out_lin"},  {16'd0, pxl_l}, 32'd0);
    chk({tag, "_valid_out"},    {30'd0, vo_r, vo_l}, 32'd0);
    chk({tag, "_ch_out_idx"},   {30'd0, idx_r, idx_l}, 32'd0);
    chk({tag, "_layer_done"},   {30'd0, ld_r, ld_l}, 32'd0);
  endtask

  initial begin
    reset    = 1'b0;
    valid_in = 1'b0;
    pxl_in   = '0;
    #2;
    reset_checks("reset");
    @(posedge clk); #1;
    reset = 1'b1;

    // Constant stream: 4 pulses of 3, idx 0 -> 1 after beat 12
    vcnt = 0;
    for (int i = 0; i < 11; i++) begin
      beat(1'b1, 16'd1);
      chk("const_idx_hold", {31'd0, idx_r}, 32'd0);
    end
    beat(1'b1, 16'd1);
    chk("const_idx_step", {31'd0, idx_r}, 32'd1);
    beat(1'b0, 16'd0);
    chk("const_pulse_count", vcnt, 32'd4);

    // Per-pixel accumulation: 30,33,36,39 (closes layer 1)
    for (int c = 0; c < 3; c++)
      for (int p = 0; p < 4; p++)
        beat(1'b1, 16'(10 * c + p));

    // Negative results
    frames(3, -16'sd5);

    // Saturation both ways, then mixed clamp-and-recover
    frames(3, 16'd20000);
    frames(3, -16'sd20000);
    frames(1, 16'd30000);
    frames(1, 16'd30000);
    frames(1, -16'sd30000);
    beat(1'b0, 16'd0);

    // Two full layers from a layer boundary
    vcnt = 0; ld_cnt = 0; ld_pos1 = 0; ld_pos2 = 0;
    for (int i = 0; i < 48; i++)
      beat(1'b1, 16'($urandom_range(0, 400)) - 16'd200);
    beat(1'b0, 16'd0);
    chk("layer_pulse_count", vcnt, 32'd16);
    chk("layer_done_count", ld_cnt, 32'd2);
    chk("layer_done_pos1", ld_pos1, 32'd8);
    chk("layer_done_pos2", ld_pos2, 32'd16);

    // Gapped constant stream
    vcnt = 0;
    for (int i = 0; i < 12; i++) begin
      while ($urandom_range(0, 2) == 0) beat(1'b0, 16'($urandom));
      beat(1'b1, 16'd1);
    end
    beat(1'b0, 16'd0);
    beat(1'b0, 16'd0);
    chk("gap_pulse_count", vcnt, 32'd4);

    // Reset mid-frame, then a clean 12-beat frame of 2s
    frames(1, 16'd7);
    beat(1'b1, 16'd7);
    reset = 1'b0;
    #2;
    reset_checks("midreset");
    m_pix = 0; m_cin = 0; m_cout = 0;
    q.delete();
    @(posedge clk); #1;
    reset_checks("midreset_held");
    reset = 1'b1;
    vcnt = 0;
    frames(3, 16'd2);
    beat(1'b0, 16'd0);
    beat(1'b0, 16'd0);
    chk("post_reset_pulse_count", vcnt, 32'd4);
    chk("scoreboard_drained", q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
